// File: rtl/wu_fetch_pkg.sv
// Shared types and defaults for the WU fetch controller.
// The state encoding and credit/latency defaults are shared by the top and the bench.
package wu_fetch_pkg;

    localparam int RD_LAT_DEF  = 2;
    localparam int CREDITS_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        FETCH,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/wu_fetch_credit_ctr.sv
// Saturating up/down counter with overflow and underflow flags.
// It exposes the next-cycle count so the owner can make registered decisions one cycle ahead.
module wu_fetch_credit_ctr #(
    parameter int         W    = 3,
    parameter logic [W-1:0] INIT = '0,
    parameter logic [W-1:0] MAX  = '1
) (
    input  logic         clk,
    input  logic         reset_poweron_n,
    input  logic         up,
    input  logic         dn,
    output logic [W-1:0] count_nxt,
    output logic         ovf,
    output logic         unf
);

    logic [W-1:0] count;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        count_nxt = count;
        ovf       = 1'b0;
        unf       = 1'b0;
        if (up && !dn) begin
            if (count == MAX) ovf = 1'b1;
            else              count_nxt = count + 1'b1;
        end else if (dn && !up) begin
            if (count == '0) unf = 1'b1;
            else             count_nxt = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) count <= INIT;
        else                  count <= count_nxt;
    end

endmodule

// File: rtl/wu_fetch_cntl.sv
// WU fetch controller: pulses the storage-memory reload, then streams credit-paced sequential reads.
// Every output is a flop loaded from next-state values, so each decision is made one cycle ahead.
module wu_fetch_cntl
    import wu_fetch_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = 1024,
    parameter int CNT_W     = 11,
    parameter int CREDITS   = CREDITS_DEF,
    parameter int RD_LAT    = RD_LAT_DEF
) (
    input  logic              clk,
    input  logic              reset_poweron_n,
    input  logic              sys__wuf__start,
    input  logic [ADDR_W-1:0] sys__wuf__start_addr,
    input  logic [CNT_W-1:0]  sys__wuf__num_words,
    output logic              wuf__wum__load,
    output logic              wuf__wum__read,
    output logic [ADDR_W-1:0] wuf__wum__addr,
    input  logic              wum__wuf__valid,
    input  logic              wud__wuf__credit,
    output logic              wuf__sys__busy,
    output logic              wuf__sys__done,
    output logic              wuf__sys__err
);

    localparam int CRED_W = $clog2(CREDITS + 1);
    localparam int INFL_W = $clog2(RD_LAT + 1);
    localparam logic [CRED_W-1:0] CRED_MAX  = CRED_W'(CREDITS);
    localparam logic [INFL_W-1:0] INFL_MAX  = INFL_W'(RD_LAT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    remaining, rem_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [CRED_W-1:0]   cred_nxt;
    logic [INFL_W-1:0]   infl_nxt;
    logic                cred_ovf, cred_unf, infl_ovf, infl_unf;
    logic                accept, issue, read_nxt, err_nxt;

    assign accept = sys__wuf__start && (state == IDLE);
    assign issue  = wuf__wum__read;

    wu_fetch_credit_ctr #(.W(CRED_W), .INIT(CRED_MAX), .MAX(CRED_MAX)) u_credits (
        .clk             (clk),
        .reset_poweron_n (reset_poweron_n),
        .up              (wud__wuf__credit),
        .dn              (issue),
        .count_nxt       (cred_nxt),
        .ovf             (cred_ovf),
        .unf             (cred_unf)
    );

    // A read issued while RD_LAT reads are already outstanding means a valid never came back.
    wu_fetch_credit_ctr #(.W(INFL_W), .INIT('0), .MAX(INFL_MAX)) u_inflight (
        .clk             (clk),
        .reset_poweron_n (reset_poweron_n),
        .up              (issue),
        .dn              (wum__wuf__valid),
        .count_nxt       (infl_nxt),
        .ovf             (infl_ovf),
        .unf             (infl_unf)
    );

    always_comb begin
        rem_nxt  = remaining;
        addr_nxt = wuf__wum__addr;
        if (accept) begin
            rem_nxt  = sys__wuf__num_words;
            addr_nxt = sys__wuf__start_addr;
        end else if (issue) begin
            rem_nxt  = remaining - 1'b1;
            addr_nxt = (wuf__wum__addr == LAST_ADDR) ? '0 : wuf__wum__addr + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (sys__wuf__start) state_nxt = LOAD;
            LOAD:    state_nxt = FETCH;
            FETCH:   if (rem_nxt == '0) state_nxt = DRAIN;
            DRAIN:   if (infl_nxt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        read_nxt = (state_nxt == FETCH) && (rem_nxt != '0) && (cred_nxt != '0);
        err_nxt  = (accept ? 1'b0 : wuf__sys__err) | cred_ovf | cred_unf | infl_ovf | infl_unf;
    end

    always_ff @(posedge clk or negedge reset_poweron_n) begin
        if (!reset_poweron_n) begin
            state          <= IDLE;
            remaining      <= '0;
            wuf__wum__addr <= '0;
            wuf__wum__load <= 1'b0;
            wuf__wum__read <= 1'b0;
            wuf__sys__busy <= 1'b0;
            wuf__sys__done <= 1'b0;
            wuf__sys__err  <= 1'b0;
        end else begin
            state          <= state_nxt;
            remaining      <= rem_nxt;
            wuf__wum__addr <= addr_nxt;
            wuf__wum__load <= (state_nxt == LOAD);
            wuf__wum__read <= read_nxt;
            wuf__sys__busy <= (state_nxt != IDLE);
            wuf__sys__done <= (state_nxt == DONE);
            wuf__sys__err  <= err_nxt;
        end
    end

endmodule
